// File: rtl/rs_branch.sv
// rs_branch: reservation station for conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU).
//
// Holds dispatched branches until both source operands are resolved by snooping the ALU and
// load/store CDBs. Each cycle it issues at most one ready branch on registered ex* outputs
// that feed the combinational ex_branch unit.
//
// Optional feature macro: RS_BRANCH_AGE_EN
//   defined   - age matrix; the oldest ready entry issues first
//   undefined - fixed priority; the lowest-index ready entry issues first (no age state)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            ROB mispredict clear; kills all entries and the issue output
//   disp_*           dispatch interface (one branch per cycle, ignored while rs_full)
//   alu_cdb_*        ALU common data bus snoop
//   lsb_cdb_*        load/store common data bus snoop
//   rs_full          all entries valid; dispatch must stall
//   ex_branch_en     issue valid to ex_branch
//   exsrc1/exsrc2    resolved operands
//   expc, exaluop    branch PC and op
//   exoffset, exdest B-immediate and ROB tag of the branch
module rs_branch #(
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned OP_W     = 4,
  // Reserved tag meaning "operand value present, nothing to wait for"
  parameter logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_en,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_src1,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic [DATA_W-1:0] disp_src2,
  input  logic [TAG_W-1:0]  disp_tag2,
  input  logic [ADDR_W-1:0] disp_pc,
  input  logic [DATA_W-1:0] disp_offset,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_tag,
  input  logic [DATA_W-1:0] lsb_cdb_data,
  output logic              rs_full,
  output logic              ex_branch_en,
  output logic [DATA_W-1:0] exsrc1,
  output logic [DATA_W-1:0] exsrc2,
  output logic [ADDR_W-1:0] expc,
  output logic [OP_W-1:0]   exaluop,
  output logic [DATA_W-1:0] exoffset,
  output logic [TAG_W-1:0]  exdest
);

  // Entry storage
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [OP_W-1:0]     op_q   [RS_DEPTH];
  logic [OP_W-1:0]     op_d   [RS_DEPTH];
  logic [DATA_W-1:0]   val1_q [RS_DEPTH];
  logic [DATA_W-1:0]   val1_d [RS_DEPTH];
  logic [TAG_W-1:0]    tag1_q [RS_DEPTH];
  logic [TAG_W-1:0]    tag1_d [RS_DEPTH];
  logic [DATA_W-1:0]   val2_q [RS_DEPTH];
  logic [DATA_W-1:0]   val2_d [RS_DEPTH];
  logic [TAG_W-1:0]    tag2_q [RS_DEPTH];
  logic [TAG_W-1:0]    tag2_d [RS_DEPTH];
  logic [ADDR_W-1:0]   pc_q   [RS_DEPTH];
  logic [ADDR_W-1:0]   pc_d   [RS_DEPTH];
  logic [DATA_W-1:0]   off_q  [RS_DEPTH];
  logic [DATA_W-1:0]   off_d  [RS_DEPTH];
  logic [TAG_W-1:0]    dest_q [RS_DEPTH];
  logic [TAG_W-1:0]    dest_d [RS_DEPTH];

  // Issue output registers
  logic              ex_en_q, ex_en_d;
  logic [DATA_W-1:0] exsrc1_q, exsrc1_d;
  logic [DATA_W-1:0] exsrc2_q, exsrc2_d;
  logic [ADDR_W-1:0] expc_q, expc_d;
  logic [OP_W-1:0]   exop_q, exop_d;
  logic [DATA_W-1:0] exoff_q, exoff_d;
  logic [TAG_W-1:0]  exdest_q, exdest_d;

  logic [RS_DEPTH-1:0] ready;
  logic                free_vld;
  logic [IDX_W-1:0]    free_idx;
  logic                issue_vld;
  logic [IDX_W-1:0]    issue_idx;
  logic                disp_do;

`ifdef RS_BRANCH_AGE_EN
  // age_q[i][j] set: entry i is older than entry j (only meaningful for valid pairs)
  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_d [RS_DEPTH];
`endif

  assign rs_full = &valid_q;
  assign disp_do = disp_en & ~rs_full;

  function automatic logic cdb_hit(input logic             cdb_v,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] wait_tag);
    return cdb_v && (cdb_tag != TAG_FREE) && (cdb_tag == wait_tag);
  endfunction

  // Lowest-index free entry
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ready[i] = valid_q[i] && (tag1_q[i] == TAG_FREE) && (tag2_q[i] == TAG_FREE);
    end
  end

  // Select
`ifdef RS_BRANCH_AGE_EN
  always_comb begin
    logic older_ready;
    issue_vld = 1'b0;
    issue_idx = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      older_ready = 1'b0;
      for (int j = 0; j < int'(RS_DEPTH); j++) begin
        if (j != i && ready[j] && age_q[j][i]) older_ready = 1'b1;
      end
      if (ready[i] && !older_ready) begin
        issue_vld = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) age_d[i] = age_q[i];
    if (flush) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) age_d[i] = '0;
    end else if (disp_do) begin
      // New entry is younger than every currently valid entry; a retired row goes stale
      // harmlessly because comparisons are masked by ready/valid.
      age_d[free_idx] = '0;
      for (int j = 0; j < int'(RS_DEPTH); j++) begin
        if (IDX_W'(j) != free_idx) age_d[j][free_idx] = valid_q[j];
      end
    end
  end
`else
  always_comb begin
    issue_vld = 1'b0;
    issue_idx = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_vld = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Entry next state: wakeup, issue clear, dispatch write, flush
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      op_d[i]   = op_q[i];
      val1_d[i] = val1_q[i];
      tag1_d[i] = tag1_q[i];
      val2_d[i] = val2_q[i];
      tag2_d[i] = tag2_q[i];
      pc_d[i]   = pc_q[i];
      off_d[i]  = off_q[i];
      dest_d[i] = dest_q[i];
      if (valid_q[i]) begin
        // ALU CDB checked first so it wins on a duplicate tag
        if (cdb_hit(alu_cdb_valid, alu_cdb_tag, tag1_q[i])) begin
          val1_d[i] = alu_cdb_data;
          tag1_d[i] = TAG_FREE;
        end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, tag1_q[i])) begin
          val1_d[i] = lsb_cdb_data;
          tag1_d[i] = TAG_FREE;
        end
        if (cdb_hit(alu_cdb_valid, alu_cdb_tag, tag2_q[i])) begin
          val2_d[i] = alu_cdb_data;
          tag2_d[i] = TAG_FREE;
        end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, tag2_q[i])) begin
          val2_d[i] = lsb_cdb_data;
          tag2_d[i] = TAG_FREE;
        end
      end
    end

    if (issue_vld) valid_d[issue_idx] = 1'b0;

    // free_vld is implied by !rs_full; the free entry is never the issued one
    if (disp_do && free_vld) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = disp_op;
      pc_d[free_idx]    = disp_pc;
      off_d[free_idx]   = disp_offset;
      dest_d[free_idx]  = disp_dest;
      val1_d[free_idx]  = disp_src1;
      tag1_d[free_idx]  = disp_tag1;
      val2_d[free_idx]  = disp_src2;
      tag2_d[free_idx]  = disp_tag2;
      if (cdb_hit(alu_cdb_valid, alu_cdb_tag, disp_tag1)) begin
        val1_d[free_idx] = alu_cdb_data;
        tag1_d[free_idx] = TAG_FREE;
      end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, disp_tag1)) begin
        val1_d[free_idx] = lsb_cdb_data;
        tag1_d[free_idx] = TAG_FREE;
      end
      if (cdb_hit(alu_cdb_valid, alu_cdb_tag, disp_tag2)) begin
        val2_d[free_idx] = alu_cdb_data;
        tag2_d[free_idx] = TAG_FREE;
      end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_tag, disp_tag2)) begin
        val2_d[free_idx] = lsb_cdb_data;
        tag2_d[free_idx] = TAG_FREE;
      end
    end

    if (flush) valid_d = '0;
  end

  // Issue register next state
  always_comb begin
    ex_en_d  = 1'b0;
    exdest_d = TAG_FREE;
    exsrc1_d = exsrc1_q;
    exsrc2_d = exsrc2_q;
    expc_d   = expc_q;
    exop_d   = exop_q;
    exoff_d  = exoff_q;
    if (!flush && issue_vld) begin
      ex_en_d  = 1'b1;
      exdest_d = dest_q[issue_idx];
      exsrc1_d = val1_q[issue_idx];
      exsrc2_d = val2_q[issue_idx];
      expc_d   = pc_q[issue_idx];
      exop_d   = op_q[issue_idx];
      exoff_d  = off_q[issue_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      ex_en_q  <= 1'b0;
      exdest_q <= TAG_FREE;
      exsrc1_q <= '0;
      exsrc2_q <= '0;
      expc_q   <= '0;
      exop_q   <= '0;
      exoff_q  <= '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        op_q[i]   <= '0;
        val1_q[i] <= '0;
        tag1_q[i] <= TAG_FREE;
        val2_q[i] <= '0;
        tag2_q[i] <= TAG_FREE;
        pc_q[i]   <= '0;
        off_q[i]  <= '0;
        dest_q[i] <= TAG_FREE;
`ifdef RS_BRANCH_AGE_EN
        age_q[i]  <= '0;
`endif
      end
    end else begin
      valid_q  <= valid_d;
      ex_en_q  <= ex_en_d;
      exdest_q <= exdest_d;
      exsrc1_q <= exsrc1_d;
      exsrc2_q <= exsrc2_d;
      expc_q   <= expc_d;
      exop_q   <= exop_d;
      exoff_q  <= exoff_d;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        op_q[i]   <= op_d[i];
        val1_q[i] <= val1_d[i];
        tag1_q[i] <= tag1_d[i];
        val2_q[i] <= val2_d[i];
        tag2_q[i] <= tag2_d[i];
        pc_q[i]   <= pc_d[i];
        off_q[i]  <= off_d[i];
        dest_q[i] <= dest_d[i];
`ifdef RS_BRANCH_AGE_EN
        age_q[i]  <= age_d[i];
`endif
      end
    end
  end

  assign ex_branch_en = ex_en_q;
  assign exsrc1       = exsrc1_q;
  assign exsrc2       = exsrc2_q;
  assign expc         = expc_q;
  assign exaluop      = exop_q;
  assign exoffset     = exoff_q;
  assign exdest       = exdest_q;

endmodule

// File: tb/tb_rs_branch.sv
// Directed self-checking bench for rs_branch (default parameters).
module tb_rs_branch;

  localparam logic [4:0] FREE = 5'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_en;
  logic [3:0]  disp_op;
  logic [31:0] disp_src1, disp_src2, disp_pc, disp_offset;
  logic [4:0]  disp_tag1, disp_tag2, disp_dest;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [4:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_data, lsb_cdb_data;
  logic        rs_full, ex_branch_en;
  logic [31:0] exsrc1, exsrc2, expc, exoffset;
  logic [3:0]  exaluop;
  logic [4:0]  exdest;

  int checks = 0;
  int failures = 0;

  rs_branch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .disp_en      (disp_en),
    .disp_op      (disp_op),
    .disp_src1    (disp_src1),
    .disp_tag1    (disp_tag1),
    .disp_src2    (disp_src2),
    .disp_tag2    (disp_tag2),
    .disp_pc      (disp_pc),
    .disp_offset  (disp_offset),
    .disp_dest    (disp_dest),
    .alu_cdb_valid(alu_cdb_valid),
    .alu_cdb_tag  (alu_cdb_tag),
    .alu_cdb_data (alu_cdb_data),
    .lsb_cdb_valid(lsb_cdb_valid),
    .lsb_cdb_tag  (lsb_cdb_tag),
    .lsb_cdb_data (lsb_cdb_data),
    .rs_full      (rs_full),
    .ex_branch_en (ex_branch_en),
    .exsrc1       (exsrc1),
    .exsrc2       (exsrc2),
    .expc         (expc),
    .exaluop      (exaluop),
    .exoffset     (exoffset),
    .exdest       (exdest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] s1, input logic [4:0] t1,
                      input logic [31:0] s2, input logic [4:0] t2, input logic [31:0] pc,
                      input logic [31:0] off, input logic [4:0] dest);
    disp_en = 1'b1;
    disp_op = op;
    disp_src1 = s1;
    disp_tag1 = t1;
    disp_src2 = s2;
    disp_tag2 = t2;
    disp_pc = pc;
    disp_offset = off;
    disp_dest = dest;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    disp_en = 1'b0;
    disp_op = '0;
    disp_src1 = '0;
    disp_src2 = '0;
    disp_pc = '0;
    disp_offset = '0;
    disp_tag1 = FREE;
    disp_tag2 = FREE;
    disp_dest = FREE;
    alu_cdb_valid = 1'b0;
    alu_cdb_tag = FREE;
    alu_cdb_data = '0;
    lsb_cdb_valid = 1'b0;
    lsb_cdb_tag = FREE;
    lsb_cdb_data = '0;

    // Reset
    repeat (3) tick();
    chk("rst_full", rs_full, 0);
    chk("rst_en", ex_branch_en, 0);
    chk("rst_dest", exdest, FREE);
    chk("rst_src1", exsrc1, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_en", ex_branch_en, 0);

    // Ready-at-dispatch BEQ
    disp(4'd0, 32'd5, FREE, 32'd5, FREE, 32'h100, 32'h20, 5'd3);
    tick();
    disp_en = 1'b0;
    chk("beq_edge1_en", ex_branch_en, 0);
    tick();
    chk("beq_en", ex_branch_en, 1);
    chk("beq_src1", exsrc1, 32'd5);
    chk("beq_src2", exsrc2, 32'd5);
    chk("beq_pc", expc, 32'h100);
    chk("beq_off", exoffset, 32'h20);
    chk("beq_dest", exdest, 5'd3);
    chk("beq_op", exaluop, 4'd0);
    tick();
    chk("beq_once_en", ex_branch_en, 0);
    chk("beq_once_dest", exdest, FREE);
    chk("beq_hold_pc", expc, 32'h100);

    // BLT waiting on tag 2, woken by ALU CDB
    disp(4'd2, 32'd0, 5'd2, 32'd7, FREE, 32'h200, 32'h40, 5'd4);
    tick();
    disp_en = 1'b0;
    tick();
    chk("blt_wait1", ex_branch_en, 0);
    tick();
    chk("blt_wait2", ex_branch_en, 0);
    alu_cdb_valid = 1'b1;
    alu_cdb_tag = 5'd2;
    alu_cdb_data = 32'hFFFF_FFFF;
    tick();
    alu_cdb_valid = 1'b0;
    alu_cdb_tag = FREE;
    chk("blt_capture_edge", ex_branch_en, 0);
    tick();
    chk("blt_en", ex_branch_en, 1);
    chk("blt_src1", exsrc1, 32'hFFFF_FFFF);
    chk("blt_src2", exsrc2, 32'd7);
    chk("blt_dest", exdest, 5'd4);
    chk("blt_op", exaluop, 4'd2);

    // Same-cycle capture from the load/store CDB
    disp(4'd1, 32'd1, FREE, 32'd0, 5'd6, 32'h300, 32'h8, 5'd5);
    lsb_cdb_valid = 1'b1;
    lsb_cdb_tag = 5'd6;
    lsb_cdb_data = 32'h40;
    tick();
    disp_en = 1'b0;
    lsb_cdb_valid = 1'b0;
    lsb_cdb_tag = FREE;
    chk("cap_edge1_en", ex_branch_en, 0);
    tick();
    chk("cap_en", ex_branch_en, 1);
    chk("cap_src2", exsrc2, 32'h40);
    chk("cap_src1", exsrc1, 32'd1);
    chk("cap_dest", exdest, 5'd5);
    tick();

    // Fill four unready entries, all waiting on tag 7
    for (int i = 0; i < 4; i++) begin
      disp(4'd4, 32'd0, 5'd7, 32'(i), FREE, 32'h400 + 32'(4 * i), 32'h10, 5'(10 + i));
      tick();
      chk("fill_en", ex_branch_en, 0);
    end
    chk("full_set", rs_full, 1);
    // Fifth dispatch is ready but must be dropped
    disp(4'd5, 32'd9, FREE, 32'd9, FREE, 32'h500, 32'h4, 5'd14);
    tick();
    disp_en = 1'b0;
    chk("full_hold", rs_full, 1);
    chk("full_no_issue", ex_branch_en, 0);
    alu_cdb_valid = 1'b1;
    alu_cdb_tag = 5'd7;
    alu_cdb_data = 32'h77;
    tick();
    alu_cdb_valid = 1'b0;
    alu_cdb_tag = FREE;
    chk("wake_edge_en", ex_branch_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_en", ex_branch_en, 1);
      chk("drain_dest", exdest, 5'(10 + i));
      chk("drain_src1", exsrc1, 32'h77);
      chk("drain_src2", exsrc2, 32'(i));
      chk("drain_full", rs_full, 0);
    end
    tick();
    chk("dropped_no_issue", ex_branch_en, 0);
    chk("dropped_dest", exdest, FREE);

    // Flush with three pending entries and one issue in flight
    for (int i = 0; i < 3; i++) begin
      disp(4'd3, 32'd0, 5'd9, 32'd0, FREE, 32'h600, 32'h0, 5'(1 + i));
      tick();
    end
    disp(4'd3, 32'd1, FREE, 32'd2, FREE, 32'h700, 32'h0, 5'd8);
    tick();
    disp_en = 1'b0;
    chk("pre_flush_full", rs_full, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_en", ex_branch_en, 0);
    chk("flush_full", rs_full, 0);
    chk("flush_dest", exdest, FREE);
    alu_cdb_valid = 1'b1;
    alu_cdb_tag = 5'd9;
    alu_cdb_data = 32'h99;
    tick();
    alu_cdb_valid = 1'b0;
    alu_cdb_tag = FREE;
    tick();
    chk("post_flush_en1", ex_branch_en, 0);
    tick();
    chk("post_flush_en2", ex_branch_en, 0);
    chk("post_flush_dest", exdest, FREE);

    // Asynchronous reset mid-operation discards a ready entry
    disp(4'd0, 32'd3, FREE, 32'd3, FREE, 32'h800, 32'h0, 5'd2);
    tick();
    disp_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_full", rs_full, 0);
    rst_n = 1'b1;
    tick();
    chk("async_rst_en", ex_branch_en, 0);
    tick();
    chk("async_rst_en2", ex_branch_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
